// File: rtl/alu_program_sequencer_if.sv
// Memory-subsystem and tinyALU signal bundle between the program sequencer and its slaves.
interface alu_program_sequencer_if #(
    parameter int unsigned ADDR_W = 14
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned OP_W   = 3;

    // memory side
    logic              read_req;
    logic              write_req;
    logic [ADDR_W-1:0] addrout;
    logic [BYTE_W-1:0] datatoinst;
    logic [WORD_W-1:0] datatomem;
    logic              mem_done;

    // ALU side
    logic [BYTE_W-1:0] A;
    logic [BYTE_W-1:0] B;
    logic [OP_W-1:0]   op;
    logic              start;
    logic              done;
    logic [WORD_W-1:0] result;

    modport master (
        output read_req, write_req, addrout, datatomem, A, B, op, start,
        input  datatoinst, mem_done, done, result
    );

    modport slave (
        input  read_req, write_req, addrout, datatomem, A, B, op, start,
        output datatoinst, mem_done, done, result
    );
endinterface

// File: rtl/alu_program_sequencer.sv
// Program sequencer: fetches 3-byte instructions, runs them on the tinyALU and
// stores each 16-bit result to the result region. Every output is registered.
module alu_program_sequencer #(
    parameter int unsigned       ADDR_W    = 14,
    parameter logic [ADDR_W-1:0] PROG_BASE = ADDR_W'(0),
    parameter logic [ADDR_W-1:0] RES_BASE  = ADDR_W'(14'h2000),
    parameter int unsigned       TIMEOUT   = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    run,
    output logic                    busy,
    output logic                    halted,
    output logic                    error,
    output logic [15:0]             instr_count,
    alu_program_sequencer_if.master bus
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned PC_W   = ADDR_W + 1;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic [OP_W-1:0]   OP_NOP  = 3'b000;
    localparam logic [WORD_W-1:0] CNT_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_F0,
        S_F1,
        S_F2,
        S_EXEC,
        S_STORE,
        S_HALTED,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [OP_W-1:0]   op_l_q, op_l_d;
    logic [BYTE_W-1:0] a_l_q, a_l_d;
    logic [WORD_W-1:0] result_q, result_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [BYTE_W-1:0] a_q, a_d;
    logic [BYTE_W-1:0] b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic              error_q, error_d;
    logic [WORD_W-1:0] cnt_q, cnt_d;

    logic [ADDR_W-1:0] res_addr;
    logic              pc_out_of_range;
    logic [WORD_W-1:0] cnt_inc;

    // Result slot address (wraps naturally at the top of the address space).
    assign res_addr = RES_BASE + idx_q;

    // The last byte of the next instruction must lie below the result region.
    assign pc_out_of_range = (PC_W'(pc_q) + PC_W'(2)) >= PC_W'(RES_BASE);

    // Saturating completed-instruction count.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + WORD_W'(1);

    // State and output registers; reset aborts any request in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            pc_q     <= PROG_BASE;
            idx_q    <= '0;
            op_l_q   <= '0;
            a_l_q    <= '0;
            result_q <= '0;
            tmo_q    <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            idx_q    <= idx_d;
            op_l_q   <= op_l_d;
            a_l_q    <= a_l_d;
            result_q <= result_d;
            tmo_q    <= tmo_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            error_q  <= error_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next state and next output values. Each fetch/store state spends its
    // first cycle with the request low, which guarantees the idle gap.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        idx_d    = idx_q;
        op_l_d   = op_l_q;
        a_l_d    = a_l_q;
        result_d = result_q;
        tmo_d    = tmo_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        start_d  = start_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                pc_d = PROG_BASE;
                if (run) begin
                    state_d = S_F0;
                end
            end

            S_F0: begin
                if (!rd_q) begin
                    if (pc_out_of_range) begin
                        state_d = S_ERR;
                    end else begin
                        rd_d   = 1'b1;
                        addr_d = pc_q;
                    end
                end else if (bus.mem_done) begin
                    rd_d    = 1'b0;
                    addr_d  = '0;
                    op_l_d  = bus.datatoinst[OP_W-1:0];
                    state_d = bus.datatoinst[BYTE_W-1] ? S_HALTED : S_F1;
                end
            end

            S_F1: begin
                if (!rd_q) begin
                    rd_d   = 1'b1;
                    addr_d = pc_q + ADDR_W'(1);
                end else if (bus.mem_done) begin
                    rd_d    = 1'b0;
                    addr_d  = '0;
                    a_l_d   = bus.datatoinst;
                    state_d = S_F2;
                end
            end

            S_F2: begin
                if (!rd_q) begin
                    rd_d   = 1'b1;
                    addr_d = pc_q + ADDR_W'(2);
                end else if (bus.mem_done) begin
                    rd_d    = 1'b0;
                    addr_d  = '0;
                    pc_d    = pc_q + ADDR_W'(3);
                    a_d     = a_l_q;
                    b_d     = bus.datatoinst;
                    op_d    = op_l_q;
                    start_d = 1'b1;
                    tmo_d   = '0;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                if (op_q == OP_NOP) begin
                    // nop: one start cycle, ALU response not awaited
                    start_d = 1'b0;
                    a_d     = '0;
                    b_d     = '0;
                    op_d    = '0;
                    cnt_d   = cnt_inc;
                    state_d = S_F0;
                end else if (bus.done) begin
                    // done has priority over an expiring timeout
                    result_d = bus.result;
                    start_d  = 1'b0;
                    a_d      = '0;
                    b_d      = '0;
                    op_d     = '0;
                    state_d  = S_STORE;
                end else if (tmo_q == TMO_LAST) begin
                    start_d = 1'b0;
                    a_d     = '0;
                    b_d     = '0;
                    op_d    = '0;
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_STORE: begin
                if (!wr_q) begin
                    wr_d    = 1'b1;
                    addr_d  = res_addr;
                    wdata_d = result_q;
                end else if (bus.mem_done) begin
                    wr_d    = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                    idx_d   = (res_addr == ADDR_MAX) ? '0 : idx_q + ADDR_W'(1);
                    cnt_d   = cnt_inc;
                    state_d = S_F0;
                end
            end

            S_HALTED: begin
                state_d = S_HALTED;
            end

            S_ERR: begin
                state_d = S_ERR;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d   = !(state_d inside {S_IDLE, S_HALTED, S_ERR});
        halted_d = (state_d == S_HALTED);
        error_d  = (state_d == S_ERR);
    end

    assign bus.read_req  = rd_q;
    assign bus.write_req = wr_q;
    assign bus.addrout   = addr_q;
    assign bus.datatomem = wdata_q;
    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.op        = op_q;
    assign bus.start     = start_q;

    assign busy        = busy_q;
    assign halted      = halted_q;
    assign error       = error_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_alu_program_sequencer.sv
// Bench for alu_program_sequencer: memory and tinyALU models, a program-level
// reference model, and a per-cycle compare process.
module tb_alu_program_sequencer;

    localparam int unsigned ADDR_W   = 14;
    localparam int unsigned TIMEOUT  = 32;
    localparam int unsigned MEM_SZ   = 1 << ADDR_W;
    localparam int unsigned RES_BASE = 'h2000;
    localparam int          BUDGET   = 40000;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        int         len;   // expected start length, 0 = not checked
    } ins_t;

    typedef struct {
        logic [13:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clk;
    logic        reset_n;
    logic        run;
    logic        busy;
    logic        halted;
    logic        error;
    logic [15:0] instr_count;

    alu_program_sequencer_if #(.ADDR_W(ADDR_W)) bus_if ();

    alu_program_sequencer #(
        .ADDR_W   (ADDR_W),
        .PROG_BASE(14'h0000),
        .RES_BASE (14'h2000),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .busy       (busy),
        .halted     (halted),
        .error      (error),
        .instr_count(instr_count),
        .bus        (bus_if)
    );

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0]  mem  [MEM_SZ];
    logic [15:0] wmem [MEM_SZ];
    int          wr_count;

    int mem_lat;
    int alu_lat;
    bit alu_dead;

    ins_t exp_ins[$];
    wr_t  exp_wr[$];
    int   exp_cnt;
    bit   exp_halt;
    bit   exp_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd1:    return 16'(a) + 16'(b);
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a ^ b};
            3'd4:    return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    // Memory model: done after mem_lat extra cycles, single-cycle pulse.
    int mem_wait;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_if.mem_done   <= 1'b0;
            bus_if.datatoinst <= 8'h00;
            mem_wait          <= 0;
        end else if (bus_if.mem_done) begin
            bus_if.mem_done <= 1'b0;
        end else if (bus_if.read_req || bus_if.write_req) begin
            if (mem_wait >= mem_lat) begin
                bus_if.mem_done <= 1'b1;
                mem_wait        <= 0;
                if (bus_if.read_req) begin
                    bus_if.datatoinst <= mem[bus_if.addrout];
                end
                if (bus_if.write_req) begin
                    wmem[bus_if.addrout] <= bus_if.datatomem;
                    wr_count             <= wr_count + 1;
                end
            end else begin
                mem_wait <= mem_wait + 1;
            end
        end
    end

    // tinyALU model: done alu_lat cycles after start, ignores nop and dead mode.
    int alu_cnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_if.done   <= 1'b0;
            bus_if.result <= 16'h0000;
            alu_cnt       <= 0;
        end else if (bus_if.start && !bus_if.done && bus_if.op != 3'd0 && !alu_dead) begin
            if (alu_cnt + 1 >= alu_lat) begin
                bus_if.done   <= 1'b1;
                bus_if.result <= alu_ref(bus_if.op, bus_if.A, bus_if.B);
                alu_cnt       <= 0;
            end else begin
                alu_cnt <= alu_cnt + 1;
            end
        end else begin
            bus_if.done <= 1'b0;
            alu_cnt     <= 0;
        end
    end

    // Program-level reference: walk the program and list expected ALU ops and writes.
    task automatic build_model();
        int   pc;
        int   idx;
        bit   stop;
        ins_t e;
        wr_t  w;
        logic [7:0] b0;
        exp_ins.delete();
        exp_wr.delete();
        exp_cnt  = 0;
        exp_halt = 1'b0;
        exp_err  = 1'b0;
        pc   = 0;
        idx  = 0;
        stop = 1'b0;
        while (!stop) begin
            if (pc + 2 >= int'(RES_BASE)) begin
                exp_err = 1'b1;
                stop    = 1'b1;
            end else begin
                b0 = mem[14'(pc)];
                if (b0[7]) begin
                    exp_halt = 1'b1;
                    stop     = 1'b1;
                end else begin
                    e.op = b0[2:0];
                    e.a  = mem[14'(pc + 1)];
                    e.b  = mem[14'(pc + 2)];
                    pc   = pc + 3;
                    if (e.op == 3'd0) begin
                        e.len = 1;
                        exp_ins.push_back(e);
                        exp_cnt++;
                    end else if (alu_dead) begin
                        e.len = int'(TIMEOUT);
                        exp_ins.push_back(e);
                        exp_err = 1'b1;
                        stop    = 1'b1;
                    end else begin
                        e.len = 0;
                        exp_ins.push_back(e);
                        w.addr = 14'(int'(RES_BASE) + idx);
                        w.data = alu_ref(e.op, e.a, e.b);
                        exp_wr.push_back(w);
                        idx = (w.addr == 14'h3FFF) ? 0 : idx + 1;
                        exp_cnt++;
                    end
                end
            end
        end
    endtask

    // Per-cycle compare against the reference and the handshake rules.
    logic        p_rd, p_wr, p_done, p_start, p_err;
    logic [13:0] p_addr;
    logic [15:0] p_wdata;
    int          st_len;
    int          cur_len;
    ins_t        p_e;
    wr_t         p_w;
    always @(negedge clk) begin
        if (!reset_n) begin
            p_rd    = 1'b0;
            p_wr    = 1'b0;
            p_done  = 1'b0;
            p_start = 1'b0;
            p_err   = 1'b0;
            p_addr  = '0;
            p_wdata = '0;
            st_len  = 0;
            cur_len = 0;
        end else begin
            check("req_overlap", 32'(bus_if.read_req & bus_if.write_req), 32'd0);
            check("busy_excl", 32'(busy & (halted | error)), 32'd0);
            if (p_err) check("err_sticky", 32'(error), 32'd1);
            if ((p_rd | p_wr) && !p_done) begin
                check("req_hold", 32'({bus_if.read_req, bus_if.write_req}), 32'({p_rd, p_wr}));
                check("addr_hold", 32'(bus_if.addrout), 32'(p_addr));
                if (p_wr) check("wdata_hold", 32'(bus_if.datatomem), 32'(p_wdata));
            end
            if ((p_rd | p_wr) && p_done) begin
                check("req_drop", 32'({bus_if.read_req, bus_if.write_req}), 32'd0);
            end
            if (bus_if.write_req && bus_if.mem_done) begin
                check("wr_pending", 32'(exp_wr.size() != 0), 32'd1);
                if (exp_wr.size() != 0) begin
                    p_w = exp_wr.pop_front();
                    check("wr_addr", 32'(bus_if.addrout), 32'(p_w.addr));
                    check("wr_data", 32'(bus_if.datatomem), 32'(p_w.data));
                end
            end
            if (bus_if.start && !p_start) begin
                check("ins_pending", 32'(exp_ins.size() != 0), 32'd1);
                cur_len = 0;
                if (exp_ins.size() != 0) begin
                    p_e = exp_ins.pop_front();
                    check("alu_op", 32'(bus_if.op), 32'(p_e.op));
                    check("alu_a", 32'(bus_if.A), 32'(p_e.a));
                    check("alu_b", 32'(bus_if.B), 32'(p_e.b));
                    cur_len = p_e.len;
                end
                st_len = 1;
            end else if (bus_if.start) begin
                st_len++;
            end
            if (!bus_if.start && p_start && cur_len != 0) begin
                check("start_len", 32'(st_len), 32'(cur_len));
            end
            p_rd    = bus_if.read_req;
            p_wr    = bus_if.write_req;
            p_done  = bus_if.mem_done;
            p_start = bus_if.start;
            p_err   = error;
            p_addr  = bus_if.addrout;
            p_wdata = bus_if.datatomem;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < int'(MEM_SZ); i++) begin
            mem[i]  = 8'h00;
            wmem[i] = 16'h0000;
        end
    endtask

    task automatic put_ins(input int at, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        mem[14'(at)]     = b0;
        mem[14'(at + 1)] = b1;
        mem[14'(at + 2)] = b2;
    endtask

    task automatic setup(input int mlat, input int alat, input bit dead);
        reset_n  = 1'b0;
        run      = 1'b0;
        mem_lat  = mlat;
        alu_lat  = alat;
        alu_dead = dead;
        wr_count = 0;
        for (int i = 0; i < int'(MEM_SZ); i++) wmem[i] = 16'h0000;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        build_model();
        @(posedge clk);
        #1 run = 1'b1;
        @(posedge clk);
        #1 run = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int cyc;
        cyc = 0;
        while (!(halted || error) && cyc < BUDGET) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({name, "_finished"}, 32'(cyc < BUDGET), 32'd1);
    endtask

    task automatic final_checks(input string name);
        int wc;
        check({name, "_halted"}, 32'(halted), 32'(exp_halt));
        check({name, "_error"}, 32'(error), 32'(exp_err));
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_count"}, 32'(instr_count), 32'(exp_cnt));
        check({name, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
        check({name, "_ins_left"}, 32'(exp_ins.size()), 32'd0);
        wc = wr_count;
        repeat (5) @(posedge clk);
        #1;
        check({name, "_terminal"}, 32'({halted, error}), 32'({exp_halt, exp_err}));
        check({name, "_no_late_wr"}, 32'(wr_count), 32'(wc));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_rd"}, 32'(bus_if.read_req), 32'd0);
        check({name, "_wr"}, 32'(bus_if.write_req), 32'd0);
        check({name, "_addr"}, 32'(bus_if.addrout), 32'd0);
        check({name, "_wdata"}, 32'(bus_if.datatomem), 32'd0);
        check({name, "_alu"}, 32'({bus_if.A, bus_if.B, bus_if.op, bus_if.start}), 32'd0);
        check({name, "_status"}, 32'({busy, halted, error}), 32'd0);
        check({name, "_count"}, 32'(instr_count), 32'd0);
    endtask

    initial begin
        int cyc;
        reset_n  = 1'b0;
        run      = 1'b0;
        mem_lat  = 0;
        alu_lat  = 1;
        alu_dead = 1'b0;
        wr_count = 0;
        clear_mem();
        @(posedge clk);
        #1;
        check_all_zero("reset");

        // 1: add 3+4 then halt
        clear_mem();
        put_ins(0, 8'h01, 8'h03, 8'h04);
        mem[3] = 8'h80;
        setup(0, 1, 1'b0);
        wait_end("t1");
        final_checks("t1");
        check("t1_res0", 32'(wmem[14'h2000]), 32'h0007);
        check("t1_cnt_lit", 32'(instr_count), 32'd1);
        check("t1_halt_lit", 32'(halted), 32'd1);

        // 2: mul FF*FF, and F0&3C, halt
        clear_mem();
        put_ins(0, 8'h04, 8'hFF, 8'hFF);
        put_ins(3, 8'h02, 8'hF0, 8'h3C);
        mem[6] = 8'h80;
        setup(0, 3, 1'b0);
        wait_end("t2");
        final_checks("t2");
        check("t2_res0", 32'(wmem[14'h2000]), 32'hFE01);
        check("t2_res1", 32'(wmem[14'h2001]), 32'h0030);
        check("t2_cnt_lit", 32'(instr_count), 32'd2);

        // 3: nop then xor AA^55, halt
        clear_mem();
        put_ins(0, 8'h00, 8'h11, 8'h22);
        put_ins(3, 8'h03, 8'hAA, 8'h55);
        mem[6] = 8'h80;
        setup(0, 1, 1'b0);
        wait_end("t3");
        final_checks("t3");
        check("t3_res0", 32'(wmem[14'h2000]), 32'h00FF);
        check("t3_wr_count", 32'(wr_count), 32'd1);
        check("t3_cnt_lit", 32'(instr_count), 32'd2);

        // 4: ALU never answers
        clear_mem();
        put_ins(0, 8'h01, 8'h03, 8'h04);
        mem[3] = 8'h80;
        setup(0, 1, 1'b1);
        wait_end("t4");
        final_checks("t4");
        check("t4_err_lit", 32'(error), 32'd1);
        check("t4_no_write", 32'(wr_count), 32'd0);
        check("t4_start_low", 32'(bus_if.start), 32'd0);

        // 5: slow memory, 5 wait cycles per access
        clear_mem();
        put_ins(0, 8'h01, 8'h03, 8'h04);
        mem[3] = 8'h80;
        setup(5, 2, 1'b0);
        wait_end("t5");
        final_checks("t5");
        check("t5_res0", 32'(wmem[14'h2000]), 32'h0007);
        check("t5_cnt_lit", 32'(instr_count), 32'd1);

        // 6: reset while the write is outstanding, then rerun
        clear_mem();
        put_ins(0, 8'h01, 8'h03, 8'h04);
        mem[3] = 8'h80;
        setup(3, 3, 1'b0);
        cyc = 0;
        while (!bus_if.write_req && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("t6_wr_seen", 32'(bus_if.write_req), 32'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("t6_abort");
        @(posedge clk);
        #1;
        check("t6_no_write", 32'(wr_count), 32'd0);
        setup(0, 1, 1'b0);
        wait_end("t6");
        final_checks("t6");
        check("t6_res0", 32'(wmem[14'h2000]), 32'h0007);
        check("t6_cnt_lit", 32'(instr_count), 32'd1);

        // 7: all-nop program with no halt runs into the result-region bound
        clear_mem();
        setup(0, 1, 1'b0);
        wait_end("t7");
        final_checks("t7");
        check("t7_err_lit", 32'(error), 32'd1);
        check("t7_cnt_lit", 32'(instr_count), 32'd2730);
        check("t7_no_write", 32'(wr_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
